// File: rtl/pio_regs_pkg.sv
// Shared definitions for the PIO interrupt servicer: PIO register map,
// servicer FSM encoding and the Avalon-MM command bundle.
package pio_regs_pkg;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE_CAP = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_SAMPLE,
    ST_CLR,
    ST_GUARD
  } state_e;

  typedef struct packed {
    logic        chipselect;
    logic        write_n;
    logic [1:0]  address;
    logic [31:0] writedata;
  } avmm_cmd_t;

  localparam avmm_cmd_t BUS_IDLE = '{
    chipselect: 1'b0,
    write_n:    1'b1,
    address:    REG_DATA,
    writedata:  32'h0
  };

  function automatic avmm_cmd_t bus_write(input logic [1:0] addr, input logic [31:0] data);
    avmm_cmd_t c;
    c.chipselect = 1'b1;
    c.write_n    = 1'b0;
    c.address    = addr;
    c.writedata  = data;
    return c;
  endfunction

  function automatic avmm_cmd_t bus_read(input logic [1:0] addr);
    avmm_cmd_t c;
    c.chipselect = 1'b1;
    c.write_n    = 1'b1;
    c.address    = addr;
    c.writedata  = 32'h0;
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; pop data is the combinational head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pio_irq_servicer.sv
// Services a PIO edge-capture interrupt: reads EDGE_CAP, clears only the seen
// bits, and queues {mask, timestamp} events for a downstream consumer.
module pio_irq_servicer
  import pio_regs_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 4'hF,
  parameter int               TS_WIDTH      = 16,
  parameter int               FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                irq_in,
  output logic [1:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [31:0]         m_writedata,
  input  logic [31:0]         m_readdata,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [WIDTH-1:0]    ev_mask,
  output logic [TS_WIDTH-1:0] ev_time
);

  localparam int EV_W = WIDTH + TS_WIDTH;

  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] ts_lat_q, ts_lat_d;
  logic [WIDTH-1:0]    cap_q, cap_d;
  logic [WIDTH-1:0]    sample_cap;
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [EV_W-1:0]     ev_data;
  avmm_cmd_t           cmd;
  logic                unused_rd_bits;

  assign sample_cap     = m_readdata[WIDTH-1:0] & IRQ_MASK_INIT;
  assign unused_rd_bits = ^m_readdata[31:WIDTH];
  assign ts_d           = ts_q + TS_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      ts_q     <= '0;
      ts_lat_q <= '0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
      cap_q    <= cap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ts_lat_d = ts_lat_q;
    cap_d    = cap_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      // Not servicing while full leaves edges sticky in the PIO, so nothing is lost.
      ST_IDLE: begin
        if (irq_in && !fifo_full) begin
          state_d  = ST_RD;
          ts_lat_d = ts_q;
        end
      end
      ST_RD:   state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        cap_d   = sample_cap;
        state_d = (sample_cap == '0) ? ST_GUARD : ST_CLR;
      end
      // GUARD gives the PIO a cycle to drop irq after the clear lands.
      ST_CLR:   state_d = ST_GUARD;
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cmd  = BUS_IDLE;
    push = 1'b0;
    case (state_q)
      ST_INIT: cmd = bus_write(REG_IRQ_MASK, 32'(IRQ_MASK_INIT));
      ST_RD:   cmd = bus_read(REG_EDGE_CAP);
      // Clearing only the captured bits keeps edges that arrived mid-service.
      ST_CLR: begin
        cmd  = bus_write(REG_EDGE_CAP, 32'(cap_q));
        push = 1'b1;
      end
      default: ;
    endcase
    // The reset state is INIT, so the bus must be forced idle while reset is held.
    if (!reset_n) cmd = BUS_IDLE;
  end

  assign m_chipselect = cmd.chipselect;
  assign m_write_n    = cmd.write_n;
  assign m_address    = cmd.address;
  assign m_writedata  = cmd.writedata;

  assign ev_valid           = ~fifo_empty;
  assign pop                = ev_valid & ev_ready;
  assign {ev_mask, ev_time} = ev_data;

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({cap_q, ts_lat_q}),
    .pop       (pop),
    .pop_data  (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: a small PIO responder model, a table of single
// edge services, and hand-written sequences for the multi-cycle corner cases.
module tb_pio_irq_servicer;

  localparam int WIDTH    = 4;
  localparam int TS_WIDTH = 16;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                irq_in;
  logic [1:0]          m_address;
  logic                m_chipselect;
  logic                m_write_n;
  logic [31:0]         m_writedata;
  logic [31:0]         m_readdata;
  logic                ev_valid;
  logic                ev_ready = 1'b0;
  logic [WIDTH-1:0]    ev_mask;
  logic [TS_WIDTH-1:0] ev_time;

  int total = 0;
  int bad   = 0;

  // PIO responder model
  logic [3:0]  edge_cap_q = 4'h0;
  logic [3:0]  mask_reg_q = 4'h0;
  logic [31:0] rdata_q    = 32'h0;
  logic [3:0]  edge_in    = 4'h0;
  logic        force_irq  = 1'b0;

  // Bus monitor
  int          wr2_cnt = 0;
  int          wr3_cnt = 0;
  int          rd_cnt  = 0;
  logic [31:0] last_wdata = 32'h0;

  logic [TS_WIDTH-1:0] tb_ts;

  typedef struct {
    logic [3:0]  edges;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] drain_exp [4];

  pio_irq_servicer #(
    .WIDTH         (WIDTH),
    .IRQ_MASK_INIT (4'hF),
    .TS_WIDTH      (TS_WIDTH),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .irq_in       (irq_in),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_mask      (ev_mask),
    .ev_time      (ev_time)
  );

  always #5 clk = ~clk;

  assign irq_in     = (|(edge_cap_q & mask_reg_q)) | force_irq;
  assign m_readdata = rdata_q;

  always @(posedge clk) begin
    if (m_chipselect && !m_write_n && m_address == 2'd2) mask_reg_q <= m_writedata[3:0];
    edge_cap_q <= (edge_cap_q &
                   ~((m_chipselect && !m_write_n && m_address == 2'd3) ? m_writedata[3:0] : 4'h0))
                  | edge_in;
    rdata_q    <= (m_chipselect && m_write_n && m_address == 2'd3) ? {28'h0, edge_cap_q} : 32'h0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 16'd1;
  end

  always @(negedge clk) begin
    if (reset_n && m_chipselect) begin
      if (!m_write_n) begin
        if (m_address == 2'd2) wr2_cnt <= wr2_cnt + 1;
        if (m_address == 2'd3) wr3_cnt <= wr3_cnt + 1;
        last_wdata <= m_writedata;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr3(input int base, input string name);
    int n = 0;
    while (wr3_cnt == base && n < 20) begin
      tick();
      n++;
    end
    check({name, " clear write seen"}, 32'(wr3_cnt != base), 32'd1);
  endtask

  task automatic wait_ev(input string name);
    int n = 0;
    while (!ev_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, " event seen"}, 32'(ev_valid), 32'd1);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic check_idle_bus(input string name);
    check({name, " cs"},   32'(m_chipselect), 32'd0);
    check({name, " wr_n"}, 32'(m_write_n),    32'd1);
    check({name, " addr"}, 32'(m_address),    32'd0);
    check({name, " wd"},   m_writedata,       32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               base;
    int               rbase;
    int               w2;
    logic [TS_WIDTH-1:0] t0;
    logic [TS_WIDTH-1:0] t_first;

    vecs[0] = '{edges: 4'b0101, exp_mask: 4'h5, exp_wdata: 32'h5};
    vecs[1] = '{edges: 4'b0001, exp_mask: 4'h1, exp_wdata: 32'h1};
    vecs[2] = '{edges: 4'b1000, exp_mask: 4'h8, exp_wdata: 32'h8};
    vecs[3] = '{edges: 4'b1111, exp_mask: 4'hF, exp_wdata: 32'hF};
    vecs[4] = '{edges: 4'b0110, exp_mask: 4'h6, exp_wdata: 32'h6};
    vecs[5] = '{edges: 4'b1010, exp_mask: 4'hA, exp_wdata: 32'hA};
    drain_exp = '{4'h2, 4'h4, 4'h8, 4'h6};

    // Reset values, then the single INIT mask write.
    repeat (3) @(posedge clk);
    #1;
    check_idle_bus("reset");
    check("reset ev_valid", 32'(ev_valid), 32'd0);
    reset_n = 1'b1;
    #1;
    check("init cs",   32'(m_chipselect), 32'd1);
    check("init wr_n", 32'(m_write_n),    32'd0);
    check("init addr", 32'(m_address),    32'd2);
    check("init wd",   m_writedata,       32'h0000000F);
    tick();
    check_idle_bus("post-init");
    repeat (4) tick();
    check("init write count", 32'(wr2_cnt), 32'd1);
    check("no other traffic", 32'(wr3_cnt + rd_cnt), 32'd0);
    check("pio mask set", 32'(mask_reg_q), 32'hF);

    // Basic service latency with edge_capture=0101.
    edge_in = 4'b0101;
    tick();
    edge_in = 4'h0;
    t0 = tb_ts;
    check("c0 irq", 32'(irq_in), 32'd1);
    check_idle_bus("c0");
    tick();
    check("c1 rd cs",   32'(m_chipselect), 32'd1);
    check("c1 rd wr_n", 32'(m_write_n),    32'd1);
    check("c1 rd addr", 32'(m_address),    32'd3);
    tick();
    check_idle_bus("c2");
    tick();
    check("c3 clr cs",   32'(m_chipselect), 32'd1);
    check("c3 clr wr_n", 32'(m_write_n),    32'd0);
    check("c3 clr addr", 32'(m_address),    32'd3);
    check("c3 clr wd",   m_writedata,       32'h5);
    check("c3 no event yet", 32'(ev_valid), 32'd0);
    tick();
    check("c4 ev_valid", 32'(ev_valid), 32'd1);
    check("c4 ev_mask",  32'(ev_mask),  32'h5);
    check("c4 ev_time",  32'(ev_time),  32'(t0));
    check_idle_bus("c4");
    pop_one();
    check("c5 popped", 32'(ev_valid), 32'd0);
    repeat (2) tick();

    // Table of single-edge services.
    for (int i = 0; i < 6; i++) begin
      edge_in = vecs[i].edges;
      tick();
      edge_in = 4'h0;
      t0   = tb_ts;
      base = wr3_cnt;
      wait_wr3(base, $sformatf("vec%0d", i));
      check($sformatf("vec%0d clear data", i), last_wdata, vecs[i].exp_wdata);
      wait_ev($sformatf("vec%0d", i));
      check($sformatf("vec%0d mask", i), 32'(ev_mask), 32'(vecs[i].exp_mask));
      check($sformatf("vec%0d time", i), 32'(ev_time), 32'(t0));
      pop_one();
      check($sformatf("vec%0d drained", i), 32'(ev_valid), 32'd0);
      repeat (2) tick();
    end

    // Line 1 edge arrives during SAMPLE of a line 0 service.
    edge_in = 4'b0001;
    tick();
    edge_in = 4'h0;
    tick();
    tick();
    edge_in = 4'b0010;
    tick();
    edge_in = 4'h0;
    check("mid clr wr_n", 32'(m_write_n), 32'd0);
    check("mid clr wd",   m_writedata,    32'h1);
    tick();
    check("mid first mask", 32'(ev_mask), 32'h1);
    check("mid pio keeps line1", 32'(edge_cap_q), 32'h2);
    pop_one();
    wait_ev("mid second");
    check("mid second mask", 32'(ev_mask), 32'h2);
    check("mid second wd", last_wdata, 32'h2);
    pop_one();
    repeat (2) tick();

    // Spurious interrupt: read returns zero.
    base  = wr3_cnt;
    rbase = rd_cnt;
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    check("spur rd cs",   32'(m_chipselect), 32'd1);
    check("spur rd addr", 32'(m_address),    32'd3);
    tick();
    check_idle_bus("spur sample");
    tick();
    check_idle_bus("spur guard");
    edge_in = 4'b0100;
    tick();
    edge_in = 4'h0;
    check("spur no write", 32'(wr3_cnt), 32'(base));
    check("spur no event", 32'(ev_valid), 32'd0);
    check("spur one read", 32'(rd_cnt), 32'(rbase + 1));
    tick();
    check("spur back idle rd", 32'(m_chipselect & m_write_n), 32'd1);
    wait_wr3(base, "spur follow");
    check("spur follow wd", last_wdata, 32'h4);
    wait_ev("spur follow");
    check("spur follow mask", 32'(ev_mask), 32'h4);
    pop_one();
    repeat (2) tick();

    // FIFO full: four queued, fifth waits for a pop.
    for (int k = 0; k < 4; k++) begin
      edge_in = 4'(1 << k);
      tick();
      edge_in = 4'h0;
      if (k == 0) t_first = tb_ts;
      base = wr3_cnt;
      wait_wr3(base, $sformatf("fill%0d", k));
      repeat (2) tick();
    end
    rbase = rd_cnt;
    edge_in = 4'b0110;
    tick();
    edge_in = 4'h0;
    repeat (10) tick();
    check("full no read", 32'(rd_cnt), 32'(rbase));
    check("full irq pending", 32'(irq_in), 32'd1);
    check("full head mask stable", 32'(ev_mask), 32'h1);
    check("full head time stable", 32'(ev_time), 32'(t_first));
    base = wr3_cnt;
    pop_one();
    wait_wr3(base, "fifth");
    check("fifth wd", last_wdata, 32'h6);
    tick();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("drain%0d valid", j), 32'(ev_valid), 32'd1);
      check($sformatf("drain%0d mask", j), 32'(ev_mask), 32'(drain_exp[j]));
      pop_one();
    end
    check("drain empty", 32'(ev_valid), 32'd0);
    repeat (2) tick();

    // Reset asserted while in CLR.
    edge_in = 4'b1000;
    tick();
    edge_in = 4'h0;
    tick();
    tick();
    tick();
    check("pre-reset in clr", 32'(m_chipselect & ~m_write_n), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_bus("mid reset");
    check("mid reset ev_valid", 32'(ev_valid), 32'd0);
    w2 = wr2_cnt;
    repeat (2) tick();
    check("pio edge kept", 32'(edge_cap_q), 32'h8);
    reset_n = 1'b1;
    #1;
    check("reinit addr", 32'(m_address), 32'd2);
    check("reinit wd",   m_writedata,    32'hF);
    base = wr3_cnt;
    wait_wr3(base, "reservice");
    check("reservice wd", last_wdata, 32'h8);
    wait_ev("reservice");
    check("reservice mask", 32'(ev_mask), 32'h8);
    check("reinit once", 32'(wr2_cnt), 32'(w2 + 1));
    pop_one();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
